data_mem_responder: RTL and testbench

// Responder end of the core's data-memory bus (DAD/DDT/MREQ/WRITE/SIZE/ACKD_n).

---
 rtl/data_mem_responder_if.sv | 13 +
 rtl/data_mem_responder.sv | 158 +++++++++++++++
 tb/tb_data_mem_responder.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Data-memory bus between the core's MEM stage (master) and a memory responder (slave).
// DDT stays outside the interface as a plain inout wire on the responder.
interface data_mem_responder_if;
   logic [31:0] DAD;
   logic        MREQ;
   logic        WRITE;
   logic [1:0]  SIZE;
   logic        ACKD_n;
   logic        ERR;

   modport master (output DAD, MREQ, WRITE, SIZE, input ACKD_n, ERR);
   modport slave  (input DAD, MREQ, WRITE, SIZE, output ACKD_n, ERR);
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised data RAM answering byte/half/word loads and stores with an ACKD_n handshake
// after a programmable number of wait states; faulted accesses complete with ERR=1.
module data_mem_responder #(
   parameter int unsigned DEPTH_WORDS = 4096,
   parameter logic [31:0] BASE_ADDR   = 32'h0002_0000,
   parameter int unsigned WAIT_CYCLES = 1,
   parameter string       INIT_FILE   = ""
) (
   input  logic                        clk,
   input  logic                        reset,
   data_mem_responder_if.slave         bus,
   inout  wire  [31:0]                 DDT
);

   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic [31:0] addr_q;
   logic        wr_q;
   logic [1:0]  size_q;
   logic        fault_q;
   logic [31:0] rdata_p1;
   logic        ackd_n_q;
   logic        err_q;

   logic [31:0] mem [DEPTH_WORDS];

   function automatic logic [AW-1:0] index_of(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE_ADDR;
      return off[AW+1:2];
   endfunction

   // Offset wraps mod 2^32, so addresses below BASE_ADDR land far out of range.
   function automatic logic is_fault(input logic [31:0] a, input logic [1:0] sz);
      logic [31:0] off;
      logic        bad;
      off = a - BASE_ADDR;
      bad = ((off >> 2) >= 32'(DEPTH_WORDS));
      case (sz)
         2'b00:   bad = bad;
         2'b01:   bad = bad | a[0];
         2'b10:   bad = bad | (|a[1:0]);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   function automatic logic [31:0] read_lane(input logic [31:0] w, input logic [1:0] lane,
                                             input logic [1:0] sz);
      logic [31:0] sh;
      sh = w >> {lane, 3'b000};
      case (sz)
         2'b00:   return {24'b0, sh[7:0]};
         2'b01:   return {16'b0, sh[15:0]};
         2'b10:   return w;
         default: return 32'b0;
      endcase
   endfunction

   function automatic logic [31:0] merge_lane(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [1:0] lane, input logic [1:0] sz);
      logic [31:0] m;
      logic [31:0] d;
      case (sz)
         2'b00: begin
            m = 32'h0000_00FF << {lane, 3'b000};
            d = {24'b0, wd[7:0]} << {lane, 3'b000};
         end
         2'b01: begin
            m = 32'h0000_FFFF << {lane, 3'b000};
            d = {16'b0, wd[15:0]} << {lane, 3'b000};
         end
         2'b10: begin
            m = 32'hFFFF_FFFF;
            d = wd;
         end
         default: begin
            m = 32'h0;
            d = 32'h0;
         end
      endcase
      return (old & ~m) | (d & m);
   endfunction

   function automatic logic [31:0] form_read(input logic [31:0] a, input logic [1:0] sz);
      if (is_fault(a, sz)) return 32'b0;
      return read_lane(mem[index_of(a)], a[1:0], sz);
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= 4'd0;
         ackd_n_q <= 1'b1;
         err_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.MREQ) begin
                  addr_q  <= bus.DAD;
                  wr_q    <= bus.WRITE;
                  size_q  <= bus.SIZE;
                  fault_q <= is_fault(bus.DAD, bus.SIZE);
                  cnt     <= 4'(WAIT_CYCLES);
                  if (WAIT_CYCLES == 0) begin
                     state    <= ACK;
                     ackd_n_q <= 1'b0;
                     err_q    <= is_fault(bus.DAD, bus.SIZE);
                     rdata_p1 <= form_read(bus.DAD, bus.SIZE);
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            // Dropping MREQ while waiting abandons the access without side effects.
            WAIT: begin
               if (!bus.MREQ) begin
                  state <= IDLE;
                  cnt   <= 4'd0;
               end else begin
                  cnt <= cnt - 4'd1;
                  if (cnt <= 4'd1) begin
                     state    <= ACK;
                     ackd_n_q <= 1'b0;
                     err_q    <= fault_q;
                     rdata_p1 <= form_read(addr_q, size_q);
                  end
               end
            end
            ACK: begin
               state    <= IDLE;
               ackd_n_q <= 1'b1;
               err_q    <= 1'b0;
            end
            default: begin
               state    <= IDLE;
               ackd_n_q <= 1'b1;
               err_q    <= 1'b0;
            end
         endcase
      end
   end

   // Store data is taken from DDT at the edge closing the ACK cycle; a reset on that edge drops it.
   always_ff @(posedge clk) begin
      if (!reset && state == ACK && wr_q && !fault_q)
         mem[index_of(addr_q)] <= merge_lane(mem[index_of(addr_q)], DDT, addr_q[1:0], size_q);
   end

   assign DDT        = (state == ACK && !wr_q) ? rdata_p1 : {32{1'bz}};
   assign bus.ACKD_n = ackd_n_q;
   assign bus.ERR    = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: three instances with 0, 1 and 3 wait states.
module tb_data_mem_responder;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [31:0] dad [3];
   logic [1:0]  sz  [3];
   logic [31:0] wd  [3];
   logic [2:0]  mreq, wr, drv;
   logic [2:0]  ackn, errs;
   logic [31:0] rd  [3];
   wire  [31:0] ddt0, ddt1, ddt2;

   data_mem_responder_if bus0 ();
   data_mem_responder_if bus1 ();
   data_mem_responder_if bus2 ();

   assign bus0.DAD = dad[0];  assign bus0.MREQ = mreq[0];  assign bus0.WRITE = wr[0];  assign bus0.SIZE = sz[0];
   assign bus1.DAD = dad[1];  assign bus1.MREQ = mreq[1];  assign bus1.WRITE = wr[1];  assign bus1.SIZE = sz[1];
   assign bus2.DAD = dad[2];  assign bus2.MREQ = mreq[2];  assign bus2.WRITE = wr[2];  assign bus2.SIZE = sz[2];

   assign ddt0 = drv[0] ? wd[0] : {32{1'bz}};
   assign ddt1 = drv[1] ? wd[1] : {32{1'bz}};
   assign ddt2 = drv[2] ? wd[2] : {32{1'bz}};
   assign rd[0] = ddt0;
   assign rd[1] = ddt1;
   assign rd[2] = ddt2;
   assign ackn  = {bus2.ACKD_n, bus1.ACKD_n, bus0.ACKD_n};
   assign errs  = {bus2.ERR, bus1.ERR, bus0.ERR};

   data_mem_responder #(.WAIT_CYCLES(0)) u_w0 (.clk(clk), .reset(reset), .bus(bus0), .DDT(ddt0));
   data_mem_responder #(.WAIT_CYCLES(1)) u_w1 (.clk(clk), .reset(reset), .bus(bus1), .DDT(ddt1));
   data_mem_responder #(.WAIT_CYCLES(3)) u_w3 (.clk(clk), .reset(reset), .bus(bus2), .DDT(ddt2));

   int n_tests = 0;
   int n_fail  = 0;
   int lat_w [3] = '{0, 1, 3};

   typedef struct {
      logic        wr;
      logic [31:0] rdata;
      logic        err;
      string       tag;
   } exp_t;
   exp_t sb [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", tag, got, exp);
      end
   endtask

   task automatic xact(input int d, input logic w, input logic [1:0] s, input logic [31:0] a,
                       input logic [31:0] data, input logic [31:0] exp_rd, input logic exp_err,
                       input string tag);
      exp_t e;
      int   n;
      logic got;
      @(negedge clk);
      dad[d] = a; wr[d] = w; sz[d] = s; wd[d] = data; drv[d] = w; mreq[d] = 1'b1;
      e = '{w, exp_rd, exp_err, tag};
      sb.push_back(e);
      n = 0;
      got = 1'b0;
      while (!got && n < 40) begin
         @(posedge clk); #1;
         n++;
         if (ackn[d] == 1'b0) got = 1'b1;
      end
      e = sb.pop_front();
      if (!got) begin
         check({e.tag, "_timeout"}, 32'd0, 32'd1);
      end else begin
         check({e.tag, "_lat"}, n, lat_w[d] + 1);
         check({e.tag, "_err"}, {31'b0, errs[d]}, {31'b0, e.err});
         if (!e.wr) check({e.tag, "_rd"}, rd[d], e.rdata);
         @(posedge clk); #1;
         mreq[d] = 1'b0; drv[d] = 1'b0;
         check({e.tag, "_ack1"}, {31'b0, ackn[d]}, 32'd1);
      end
      mreq[d] = 1'b0; drv[d] = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int zeros;
      int n;
      for (int i = 0; i < 3; i++) begin
         dad[i] = 32'h0; sz[i] = 2'b00; wd[i] = 32'h0;
      end
      mreq = 3'b000; wr = 3'b000; drv = 3'b000;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ackn", {29'b0, ackn}, 32'h7);
      check("rst_err",  {29'b0, errs}, 32'h0);
      @(negedge clk);
      reset = 1'b0;

      // one wait state: word, byte merge, lanes, faults
      xact(1, 1'b1, 2'b10, 32'h0002_0010, 32'hDEAD_BEEF, 32'h0, 1'b0, "st_w");
      xact(1, 1'b0, 2'b10, 32'h0002_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, "ld_w");
      xact(1, 1'b1, 2'b10, 32'h0002_0010, 32'h1122_3344, 32'h0, 1'b0, "st_base");
      xact(1, 1'b1, 2'b00, 32'h0002_0013, 32'h0000_00AA, 32'h0, 1'b0, "st_b");
      xact(1, 1'b0, 2'b10, 32'h0002_0010, 32'h0, 32'hAA22_3344, 1'b0, "ld_merge");
      xact(1, 1'b0, 2'b00, 32'h0002_0013, 32'h0, 32'h0000_00AA, 1'b0, "ld_b3");
      xact(1, 1'b0, 2'b00, 32'h0002_0010, 32'h0, 32'h0000_0044, 1'b0, "ld_b0");
      xact(1, 1'b0, 2'b01, 32'h0002_0012, 32'h0, 32'h0000_AA22, 1'b0, "ld_h2");
      xact(1, 1'b1, 2'b01, 32'h0002_0010, 32'hFFFF_5566, 32'h0, 1'b0, "st_h0");
      xact(1, 1'b0, 2'b10, 32'h0002_0010, 32'h0, 32'hAA22_5566, 1'b0, "ld_hmerge");
      xact(1, 1'b0, 2'b01, 32'h0002_0011, 32'h0, 32'h0, 1'b1, "ld_h_mis");
      xact(1, 1'b1, 2'b10, 32'h0002_0012, 32'h0BAD_0BAD, 32'h0, 1'b1, "st_w_mis");
      xact(1, 1'b0, 2'b10, 32'h0002_0010, 32'h0, 32'hAA22_5566, 1'b0, "ld_after_mis");
      xact(1, 1'b1, 2'b10, 32'h0002_0000, 32'h0000_0055, 32'h0, 1'b0, "st_w0");
      xact(1, 1'b1, 2'b10, 32'h0002_4000, 32'h0000_0099, 32'h0, 1'b1, "st_oor");
      xact(1, 1'b0, 2'b10, 32'h0002_0000, 32'h0, 32'h0000_0055, 1'b0, "ld_w0");
      xact(1, 1'b0, 2'b11, 32'h0002_0000, 32'h0, 32'h0, 1'b1, "ld_sz3");
      xact(1, 1'b0, 2'b10, 32'h0001_FFFC, 32'h0, 32'h0, 1'b1, "ld_below");
      xact(1, 1'b1, 2'b10, 32'h0002_3FFC, 32'h7777_1234, 32'h0, 1'b0, "st_last");
      xact(1, 1'b0, 2'b10, 32'h0002_3FFC, 32'h0, 32'h7777_1234, 1'b0, "ld_last");

      // zero wait states
      xact(0, 1'b1, 2'b10, 32'h0002_0010, 32'hA5A5_5A5A, 32'h0, 1'b0, "w0_st");
      xact(0, 1'b0, 2'b10, 32'h0002_0010, 32'h0, 32'hA5A5_5A5A, 1'b0, "w0_ld");

      // MREQ held through ACK: IDLE cycle before the second ACK
      @(negedge clk);
      dad[0] = 32'h0002_0010; wr[0] = 1'b0; sz[0] = 2'b10; mreq[0] = 1'b1;
      @(posedge clk); #1;
      check("hold_ack1", {31'b0, ackn[0]}, 32'd0);
      check("hold_rd1", rd[0], 32'hA5A5_5A5A);
      @(posedge clk); #1;
      check("hold_idle", {31'b0, ackn[0]}, 32'd1);
      @(posedge clk); #1;
      check("hold_ack2", {31'b0, ackn[0]}, 32'd0);
      mreq[0] = 1'b0;
      @(posedge clk); #1;
      check("hold_end", {31'b0, ackn[0]}, 32'd1);

      // three wait states, request abandoned mid-wait
      xact(2, 1'b1, 2'b10, 32'h0002_0040, 32'h0102_0304, 32'h0, 1'b0, "w3_st");
      @(negedge clk);
      dad[2] = 32'h0002_0040; wr[2] = 1'b1; sz[2] = 2'b10; wd[2] = 32'hCAFE_F00D;
      drv[2] = 1'b1; mreq[2] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      mreq[2] = 1'b0; drv[2] = 1'b0;
      zeros = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (ackn[2] == 1'b0) zeros++;
      end
      check("abort_no_ack", zeros, 32'd0);
      xact(2, 1'b0, 2'b10, 32'h0002_0040, 32'h0, 32'h0102_0304, 1'b0, "abort_ld");

      // reset landing on the ACK cycle of a store
      xact(1, 1'b1, 2'b10, 32'h0002_0080, 32'h0BAD_F00D, 32'h0, 1'b0, "rst_pre_st");
      @(negedge clk);
      dad[1] = 32'h0002_0080; wr[1] = 1'b1; sz[1] = 2'b10; wd[1] = 32'h1234_5678;
      drv[1] = 1'b1; mreq[1] = 1'b1;
      n = 0;
      while (ackn[1] != 1'b0 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check("rst_ack_seen", {31'b0, ackn[1]}, 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;
      check("rst_ack_gone", {31'b0, ackn[1]}, 32'd1);
      mreq[1] = 1'b0; drv[1] = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      xact(1, 1'b0, 2'b10, 32'h0002_0080, 32'h0, 32'h0BAD_F00D, 1'b0, "rst_ld");

      check("sb_empty", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
